cdc_wr_packer: RTL and testbench

- Write-side packetizer that sits directly upstream of the asynchronous CDC FIFO, in the i_wclk domain.
- Accepts a request (address, burst length, direction) plus write-data beats with valid/ready handshakes.
- Serializes them into 65-bit FIFO words: one header word, then the data words.
- Drives the FIFO write strobe and obeys the FIFO's registered full flag.

---
 rtl/cdc_wr_packer.sv | 144 ++++++++++++++
 tb/tb_cdc_wr_packer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_wr_packer.sv
// cdc_wr_packer: write-side packetizer feeding an asynchronous CDC FIFO (i_wclk domain).
// Takes a request (address, burst length, direction) and, for writes, a stream of 64-bit
// beats. It serializes them into 65-bit FIFO words: one header word, then one word per beat.
// A single registered word slot drives the FIFO write port. The slot holds its word while
// the FIFO reports full.
//
// Ports:
//   i_nrst, i_wclk            asynchronous active-low reset, write-domain clock
//   i_req_valid/o_req_ready   request handshake; i_req_addr, i_req_len (beats-1), i_req_write
//   i_wdata_valid/o_wdata_ready  beat handshake; i_wdata, i_wlast
//   o_fifo_wr, o_fifo_wdata   FIFO write strobe and word (held while pending)
//   i_fifo_wfull              registered FIFO full flag
//   o_busy                    burst in progress or word pending
//   o_err                     sticky i_wlast mismatch (only with CDC_WR_PACKER_LASTCHK_EN)
//
// Optional feature macro: CDC_WR_PACKER_LASTCHK_EN. When it is defined, i_wlast is checked
// against the beat count, and an early i_wlast ends the burst.
module cdc_wr_packer #(
  parameter int unsigned abits = 48,
  parameter int unsigned lbits = 8,
  parameter int unsigned dbits = 65
) (
  input  logic             i_nrst,
  input  logic             i_wclk,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [abits-1:0] i_req_addr,
  input  logic [lbits-1:0] i_req_len,
  input  logic             i_req_write,
  input  logic             i_wdata_valid,
  output logic             o_wdata_ready,
  input  logic [63:0]      i_wdata,
  input  logic             i_wlast,
  output logic             o_fifo_wr,
  output logic [dbits-1:0] o_fifo_wdata,
  input  logic             i_fifo_wfull,
`ifdef CDC_WR_PACKER_LASTCHK_EN
  output logic             o_err,
`endif
  output logic             o_busy
);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e             state_q, state_d;
  logic [lbits-1:0]   cnt_q, cnt_d;
  logic               ovalid_q, ovalid_d;
  logic [dbits-1:0]   oword_q, oword_d;
  logic [dbits-1:0]   hdr;
  logic               slot_free;
  logic               req_fire, beat_fire;
  logic               cnt_zero, beat_end;

  // The slot can take a new word if it is empty or its word retires on this edge.
  assign slot_free = ~ovalid_q | ~i_fifo_wfull;
  assign req_fire  = i_req_valid & o_req_ready;
  assign beat_fire = i_wdata_valid & o_wdata_ready;
  assign cnt_zero  = (cnt_q == '0);

`ifdef CDC_WR_PACKER_LASTCHK_EN
  logic err_q, err_d;

  // An early i_wlast ends the burst. A missing i_wlast only flags the error.
  assign beat_end = cnt_zero | i_wlast;
  assign err_d    = err_q | (beat_fire & (i_wlast != cnt_zero));
  assign o_err    = err_q;

  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  logic unused_wlast;

  assign beat_end     = cnt_zero;
  assign unused_wlast = i_wlast;
`endif

  // Header: [64]=1, [63]=write, [62:55]=len, [54:abits]=0, [abits-1:0]=addr.
  always_comb begin
    hdr               = '0;
    hdr[64]           = 1'b1;
    hdr[63]           = i_req_write;
    hdr[55 +: lbits]  = i_req_len;
    hdr[abits-1:0]    = i_req_addr;
  end

  // State register.
  always_ff @(posedge i_wclk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      oword_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      oword_q  <= oword_d;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q & i_fifo_wfull;
    oword_d  = oword_q;
    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          ovalid_d = 1'b1;
          oword_d  = hdr;
          cnt_d    = i_req_len;
          if (i_req_write) state_d = StData;
        end
      end
      StData: begin
        if (beat_fire) begin
          ovalid_d = 1'b1;
          oword_d  = {1'b0, i_wdata};
          if (beat_end) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs.
  always_comb begin
    o_req_ready   = (state_q == StIdle) & slot_free;
    o_wdata_ready = (state_q == StData) & slot_free;
    o_fifo_wr     = ovalid_q;
    o_fifo_wdata  = oword_q;
    o_busy        = (state_q == StData) | ovalid_q;
  end

endmodule

// File: tb/tb_cdc_wr_packer.sv
// Self-checking bench for cdc_wr_packer. Expected FIFO words come from a transaction-level
// model: each request yields a header, and each beat yields one data word, in order. A monitor
// records every word that the FIFO actually takes.
module tb_cdc_wr_packer;

  logic        i_nrst = 1'b0;
  logic        i_wclk = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [47:0] i_req_addr = '0;
  logic [7:0]  i_req_len = '0;
  logic        i_req_write = 1'b0;
  logic        i_wdata_valid = 1'b0;
  logic        o_wdata_ready;
  logic [63:0] i_wdata = '0;
  logic        i_wlast = 1'b0;
  logic        o_fifo_wr;
  logic [64:0] o_fifo_wdata;
  logic        i_fifo_wfull = 1'b0;
  logic        o_busy;
`ifdef CDC_WR_PACKER_LASTCHK_EN
  logic        o_err;
`endif

  logic        force_full = 1'b0;
  logic        rand_full  = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          stalls  = 0;
  int          chk_idx = 0;
  logic [64:0] obs_q[$];
  logic [64:0] exp_q[$];

  cdc_wr_packer #(
    .abits(48),
    .lbits(8),
    .dbits(65)
  ) dut (
    .i_nrst        (i_nrst),
    .i_wclk        (i_wclk),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_addr    (i_req_addr),
    .i_req_len     (i_req_len),
    .i_req_write   (i_req_write),
    .i_wdata_valid (i_wdata_valid),
    .o_wdata_ready (o_wdata_ready),
    .i_wdata       (i_wdata),
    .i_wlast       (i_wlast),
    .o_fifo_wr     (o_fifo_wr),
    .o_fifo_wdata  (o_fifo_wdata),
    .i_fifo_wfull  (i_fifo_wfull),
`ifdef CDC_WR_PACKER_LASTCHK_EN
    .o_err         (o_err),
`endif
    .o_busy        (o_busy)
  );

  always #5 i_wclk = ~i_wclk;

  // Full flag changes shortly after each edge, like a registered flag.
  always @(posedge i_wclk) begin
    #2;
    i_fifo_wfull = force_full | (rand_full && ($urandom_range(0, 2) == 0));
  end

  // A word pending mid-cycle with full low retires on the next edge.
  always @(negedge i_wclk) begin
    if (i_nrst && o_fifo_wr && !i_fifo_wfull) obs_q.push_back(o_fifo_wdata);
  end

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] hdr_word(input logic [47:0] a, input logic [7:0] l,
                                           input logic w);
    return {1'b1, w, l, 7'd0, a};
  endfunction

  task automatic send_req(input logic [47:0] a, input logic [7:0] l, input logic w);
    int b = 0;
    bit acc = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_len   = l;
    i_req_write = w;
    while (!acc && b < 2000) begin
      @(negedge i_wclk);
      if (o_req_ready) acc = 1;
      @(posedge i_wclk);
      #1;
      b++;
    end
    i_req_valid = 1'b0;
    chk("req_accepted", 65'(acc), 65'(1));
    exp_q.push_back(hdr_word(a, l, w));
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int b = 0;
    bit acc = 0;
    i_wdata_valid = 1'b1;
    i_wdata       = d;
    i_wlast       = last;
    while (!acc && b < 2000) begin
      @(negedge i_wclk);
      if (o_wdata_ready) acc = 1;
      else stalls++;
      @(posedge i_wclk);
      #1;
      b++;
    end
    i_wdata_valid = 1'b0;
    i_wlast       = 1'b0;
    chk("beat_accepted", 65'(acc), 65'(1));
    exp_q.push_back({1'b0, d});
  endtask

  // Wait for the expected words and compare the new ones in order.
  task automatic drain_check(input string tag);
    int b = 0;
    while (obs_q.size() < exp_q.size() && b < 3000) begin
      @(posedge i_wclk);
      b++;
    end
    repeat (4) @(posedge i_wclk);
    #1;
    chk({tag, "_count"}, 65'(obs_q.size()), 65'(exp_q.size()));
    for (int i = chk_idx; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) chk(tag, obs_q[i], exp_q[i]);
    end
    chk_idx = exp_q.size();
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  l;
    logic        w;
    int          base;

    // Reset.
    repeat (3) @(posedge i_wclk);
    @(negedge i_wclk);
    chk("rst_fifo_wr", 65'(o_fifo_wr), 65'(0));
    chk("rst_req_ready", 65'(o_req_ready), 65'(1));
    chk("rst_wdata_ready", 65'(o_wdata_ready), 65'(0));
    chk("rst_busy", 65'(o_busy), 65'(0));
    chk("rst_fifo_wdata", o_fifo_wdata, 65'(0));
    @(posedge i_wclk);
    #1;
    i_nrst = 1'b1;
    repeat (2) @(posedge i_wclk);
    #1;

    // Read request: header only, next-edge latency.
    send_req(48'h0000_1234_5678, 8'd3, 1'b0);
    chk("rd_wr", 65'(o_fifo_wr), 65'(1));
    chk("rd_hdr", o_fifo_wdata, 65'h1_0180_0000_1234_5678);
    chk("rd_busy", 65'(o_busy), 65'(1));
    @(negedge i_wclk);
    chk("rd_no_beat", 65'(o_wdata_ready), 65'(0));
    chk("rd_idle_ready", 65'(o_req_ready), 65'(1));
    drain_check("rd_words");
    chk("rd_busy_done", 65'(o_busy), 65'(0));

    // Two-beat write burst.
    send_req(48'hABCD_0000_0010, 8'd1, 1'b1);
    send_beat(64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    send_beat(64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
    drain_check("wr_words");
    chk("wr_idle", 65'(o_req_ready), 65'(1));
    chk("wr_no_beat", 65'(o_wdata_ready), 65'(0));

    // Backpressure: header held for 5 clocks with a beat offered.
    send_req(48'h0000_0000_BEEF, 8'd2, 1'b1);
    force_full    = 1'b1;
    i_wdata_valid = 1'b1;
    i_wdata       = 64'h0123_4567_89AB_CDEF;
    repeat (5) begin
      @(negedge i_wclk);
      chk("bp_wr_held", 65'(o_fifo_wr), 65'(1));
      chk("bp_word_held", o_fifo_wdata, hdr_word(48'h0000_0000_BEEF, 8'd2, 1'b1));
      chk("bp_no_beat", 65'(o_wdata_ready), 65'(0));
      @(posedge i_wclk);
      #1;
    end
    force_full = 1'b0;
    i_wdata_valid = 1'b0;
    send_beat(64'h0123_4567_89AB_CDEF, 1'b0);
    chk("bp_next_word", o_fifo_wdata, {1'b0, 64'h0123_4567_89AB_CDEF});
    send_beat(64'h1111_2222_3333_4444, 1'b0);
    send_beat(64'h5555_6666_7777_8888, 1'b1);
    drain_check("bp_words");

    // Max burst at one word per clock.
    base   = exp_q.size();
    stalls = 0;
    send_req(48'hFFFF_FFFF_FFFF, 8'd255, 1'b1);
    for (int i = 0; i < 256; i++) send_beat({$urandom, $urandom}, i == 255);
    chk("max_stalls", 65'(stalls), 65'(0));
    chk("max_model_words", 65'(exp_q.size() - base), 65'(257));
    drain_check("max_words");
    chk("max_idle", 65'(o_req_ready), 65'(1));
    chk("max_no_beat", 65'(o_wdata_ready), 65'(0));
    chk("max_busy", 65'(o_busy), 65'(0));

    // Random traffic with random full.
    rand_full = 1'b1;
    for (int t = 0; t < 40; t++) begin
      l = 8'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(posedge i_wclk);
      #1;
      send_req({$urandom, 16'($urandom)}, l, w);
      if (w) begin
        for (int i = 0; i <= int'(l); i++) begin
          d = {$urandom, $urandom};
          repeat ($urandom_range(0, 1)) @(posedge i_wclk);
          #1;
          send_beat(d, i == int'(l));
        end
      end
    end
    rand_full = 1'b0;
    drain_check("rnd_words");
    chk("rnd_busy", 65'(o_busy), 65'(0));

`ifdef CDC_WR_PACKER_LASTCHK_EN
    chk("err_clear", 65'(o_err), 65'(0));
    send_req(48'h0000_0000_0C0C, 8'd3, 1'b1);
    send_beat(64'hD0, 1'b0);
    send_beat(64'hD1, 1'b0);
    send_beat(64'hD2, 1'b1);
    drain_check("err_words");
    chk("err_set", 65'(o_err), 65'(1));
    chk("err_idle", 65'(o_req_ready), 65'(1));
    send_req(48'h0000_0000_0D0D, 8'd0, 1'b0);
    drain_check("err_next");
    chk("err_sticky", 65'(o_err), 65'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
